// File: rtl/keypad_scan_fifo.sv
// Keypad matrix scanner with press/release debounce and key-code FIFO.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_fifo #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10,
  localparam int CODE_W = $clog2(ROWS * COLS),
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   Row,
  output logic [COLS-1:0]   Col,
  output logic [CODE_W-1:0] Code,
  output logic              Valid,
  input  logic              KeyRead,
  output logic [LVL_W-1:0]  Level,
  output logic              Overflow
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  if (ROWS < 2 || COLS < 2 || SCAN_DIV < 4 ||
      DEBOUNCE_SCANS < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scan_fifo: illegal parameter set");
  end

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  logic [ROWS-1:0]   row_m;
  logic [ROWS-1:0]   row_s;
  logic              col_on;
  logic [DW-1:0]     div_cnt;
  logic              slot_end;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     col_q;
  logic [CW-1:0]     col_d;
  logic [CW-1:0]     col_next;
  logic [RW-1:0]     row_q;
  logic [RW-1:0]     row_d;
  logic [RW-1:0]     low_row;
  logic [BW-1:0]     cnt_q;
  logic [BW-1:0]     cnt_d;
  logic [BW-1:0]     rel_q;
  logic [BW-1:0]     rel_d;
  logic              row_hit;
  logic              key_push;
  logic              rep_push;
  logic              push;
  logic [CODE_W-1:0] code_w;

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [LVL_W-1:0]  level_q;
  logic              ovf_q;
  logic              full;
  logic              pop;
  logic              wr_en;

  // Two-flop synchroniser on the asynchronous row inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_m <= '0;
      row_s <= '0;
    end else begin
      row_m <= Row;
      row_s <= row_m;
    end
  end

  // Slot divider; column drive is held off until the first clock after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      col_on  <= 1'b0;
    end else begin
      col_on  <= 1'b1;
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
    end
  end

  assign slot_end = (div_cnt == DW'(SCAN_DIV - 1));
  assign Col      = col_on ? (COLS'(1) << col_q) : '0;
  assign col_next = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
  assign row_hit  = row_s[row_q];
  assign code_w   = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(col_q);

  // Lowest asserted synced row wins when a press is detected
  always_comb begin
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_s[r]) low_row = RW'(r);
    end
  end

  // Scanner state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
    end
  end

  // Scan / debounce / held decisions, taken only at slot end
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    key_push = 1'b0;
    if (slot_end) begin
      unique case (state_q)
        SCAN: begin
          if (|row_s) begin
            row_d = low_row;
            rel_d = '0;
            if (DEBOUNCE_SCANS == 1) begin
              key_push = 1'b1;
              cnt_d    = '0;
              state_d  = HELD;
            end else begin
              cnt_d   = BW'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (row_hit) begin
            if (cnt_q + 1'b1 == BW'(DEBOUNCE_SCANS)) begin
              key_push = 1'b1;
              cnt_d    = '0;
              rel_d    = '0;
              state_d  = HELD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_next;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (row_hit) begin
            rel_d = '0;
          end else if (rel_q + 1'b1 == BW'(DEBOUNCE_SCANS)) begin
            rel_d   = '0;
            col_d   = col_next;
            state_d = SCAN;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int PW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  logic [PW-1:0] rep_q;
  logic [PW-1:0] rep_d;
  logic [PW-1:0] rep_inc;

  assign rep_inc = rep_q + 1'b1;

  // Held-sample counter register for auto-repeat
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rep_q <= '0;
    else       rep_q <= rep_d;
  end

  // First repeat after REPEAT_DELAY held samples, then every REPEAT_RATE
  always_comb begin
    rep_d    = rep_q;
    rep_push = 1'b0;
    if (state_q != HELD) begin
      rep_d = '0;
    end else if (slot_end) begin
      if (!row_hit) begin
        rep_d = '0;
      end else if (rep_inc == PW'(REPEAT_DELAY + REPEAT_RATE)) begin
        rep_push = 1'b1;
        rep_d    = PW'(REPEAT_DELAY);
      end else begin
        rep_d    = rep_inc;
        rep_push = (rep_inc == PW'(REPEAT_DELAY));
      end
    end
  end
`else
  assign rep_push = 1'b0;
`endif

  assign push  = key_push | rep_push;
  assign Valid = (level_q != '0);
  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop   = Valid & KeyRead;
  assign wr_en = push & (~full | pop);

  // FIFO storage; contents are qualified by Level so no reset is needed
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_q] <= code_w;
  end

  // FIFO pointers, occupancy and drop pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= push & full & ~pop;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign Code     = Valid ? mem[rd_q] : '0;
  assign Level    = level_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo (4x4, SCAN_DIV=4, 3-scan debounce).
// Auto-repeat section runs only when KEYPAD_AUTOREPEAT_EN is defined.
module tb_keypad_scan_fifo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  code;
  logic        valid;
  logic        key_read;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] keys;

  int vectors     = 0;
  int miscompares = 0;
  int ovf_cnt     = 0;
  int ovf_base;
  int pop_exp [4] = '{0, 5, 10, 15};

  always #5 clock = ~clock;

  // Keypad matrix model: a pressed key shorts its driven column to its row
  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col[c]) row[r] = 1'b1;
  end

  // Count every clock on which the drop pulse is high
  always @(posedge clock) begin
    if (overflow) ovf_cnt <= ovf_cnt + 1;
  end

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .Row(row), .Col(col),
    .Code(code), .Valid(valid), .KeyRead(key_read),
    .Level(level), .Overflow(overflow)
  );

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [3:0] row2;
  logic [3:0] col2;
  logic [3:0] code2;
  logic       valid2;
  logic       key_read2;
  logic [3:0] level2;
  logic       overflow2;

  always_comb begin
    row2 = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && col2[c]) row2[r] = 1'b1;
  end

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3), .FIFO_DEPTH(8),
    .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut_rep (
    .clock(clock), .reset(reset), .Row(row2), .Col(col2),
    .Code(code2), .Valid(valid2), .KeyRead(key_read2),
    .Level(level2), .Overflow(overflow2)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press_hold(input int k);
    keys[k] = 1'b1;
    tick(40);
    keys[k] = 1'b0;
    tick(20);
  endtask

  initial begin
`ifdef KEYPAD_AUTOREPEAT_EN
    key_read2 = 1'b0;
`endif
    keys     = '0;
    key_read = 1'b0;

    // Reset state, then key row2/col1 held from release (cycle 0)
    reset = 1'b1;
    tick(2);
    check("rst_col", 32'(col), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_code", 32'(code), 0);
    check("rst_ovf", 32'(overflow), 0);
    keys[9] = 1'b1;
    reset = 1'b0;
    tick(1);
    check("col0_first", 32'(col), 1);
    tick(4);
    check("col1", 32'(col), 2);
    tick(10);
    check("t1_nopush_c15", 32'(valid), 0);
    tick(1);
    check("t1_valid_c16", 32'(valid), 1);
    check("t1_code", 32'(code), 9);
    check("t1_level", 32'(level), 1);
    check("t1_col_frozen", 32'(col), 2);
    keys[9] = 1'b0;
    tick(11);
    check("t1_col_held_c27", 32'(col), 2);
    tick(1);
    check("t1_col_adv_c28", 32'(col), 4);
    check("t1_level_once", 32'(level), 1);
    key_read = 1'b1;
    tick(1);
    key_read = 1'b0;
    check("t1_pop_level", 32'(level), 0);
    check("t1_pop_valid", 32'(valid), 0);

    // Bounce: key 5 seen for one slot only
    reset = 1'b1;
    keys  = '0;
    tick(2);
    keys[5] = 1'b1;
    reset = 1'b0;
    tick(8);
    keys[5] = 1'b0;
    tick(1);
    check("t2_col_frozen", 32'(col), 2);
    tick(3);
    check("t2_col_next", 32'(col), 4);
    check("t2_valid", 32'(valid), 0);
    tick(8);
    check("t2_level", 32'(level), 0);

    // Fill 0,5,10,15 then overflow on key 3
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    ovf_base = ovf_cnt;
    press_hold(0);
    check("t3_lvl1", 32'(level), 1);
    press_hold(5);
    check("t3_lvl2", 32'(level), 2);
    press_hold(10);
    check("t3_lvl3", 32'(level), 3);
    press_hold(15);
    check("t3_lvl4", 32'(level), 4);
    check("t3_no_ovf", 32'(ovf_cnt - ovf_base), 0);
    press_hold(3);
    check("t3_full", 32'(level), 4);
    check("t3_ovf_once", 32'(ovf_cnt - ovf_base), 1);
    for (int i = 0; i < 4; i++) begin
      check("t3_pop_code", 32'(code), 32'(pop_exp[i]));
      key_read = 1'b1;
      tick(1);
      key_read = 1'b0;
      check("t3_pop_level", 32'(level), 32'(3 - i));
    end
    key_read = 1'b1;
    tick(1);
    key_read = 1'b0;
    check("t3_empty_read", 32'(level), 0);

    // Full FIFO: pop in the same cycle as a new push
    press_hold(1);
    press_hold(2);
    press_hold(4);
    press_hold(8);
    check("t4_full", 32'(level), 4);
    ovf_base = ovf_cnt;
    for (int i = 0; i < 40 && col != 4'b1000; i++) tick(1);
    check("t4_sync_c3", 32'(col), 8);
    keys[6] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (col == 4'b0100) break;
    end
    check("t4_sync_c2", 32'(col), 4);
    tick(11);
    check("t4_head_pre", 32'(code), 1);
    key_read = 1'b1;
    tick(1);
    key_read = 1'b0;
    check("t4_level", 32'(level), 4);
    check("t4_ovf", 32'(overflow), 0);
    check("t4_head_adv", 32'(code), 2);
    tick(1);
    check("t4_ovf_after", 32'(overflow), 0);
    keys[6] = 1'b0;
    tick(20);
    check("t4_no_ovf_total", 32'(ovf_cnt - ovf_base), 0);
    check("t4_level_end", 32'(level), 4);

    // Reset while HELD with two entries queued
    reset = 1'b1;
    keys  = '0;
    tick(2);
    keys[0] = 1'b1;
    keys[9] = 1'b1;
    reset = 1'b0;
    tick(12);
    check("t5_first", 32'(level), 1);
    keys[0] = 1'b0;
    tick(24);
    check("t5_lvl2", 32'(level), 2);
    check("t5_head", 32'(code), 0);
    reset = 1'b1;
    #1;
    check("t5_rst_valid", 32'(valid), 0);
    check("t5_rst_level", 32'(level), 0);
    check("t5_rst_col", 32'(col), 0);
    tick(2);
    reset = 1'b0;
    tick(15);
    check("t5_pre_push", 32'(level), 0);
    tick(1);
    check("t5_repush", 32'(level), 1);
    check("t5_code", 32'(code), 9);
    tick(30);
    check("t5_single", 32'(level), 1);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat: delay 5, rate 2, held 12 slot ends after confirmation
    reset = 1'b1;
    keys  = '0;
    tick(2);
    keys[9] = 1'b1;
    reset = 1'b0;
    tick(16);
    check("t6_press", 32'(level2), 1);
    tick(19);
    check("t6_c35", 32'(level2), 1);
    tick(1);
    check("t6_rep5", 32'(level2), 2);
    tick(7);
    check("t6_c43", 32'(level2), 2);
    tick(1);
    check("t6_rep7", 32'(level2), 3);
    tick(8);
    check("t6_rep9", 32'(level2), 4);
    tick(8);
    check("t6_rep11", 32'(level2), 5);
    tick(4);
    keys[9] = 1'b0;
    tick(16);
    check("t6_total", 32'(level2), 5);
    for (int i = 0; i < 5; i++) begin
      check("t6_code", 32'(code2), 9);
      key_read2 = 1'b1;
      tick(1);
      key_read2 = 1'b0;
    end
    check("t6_drained", 32'(valid2), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
